// File: rtl/pc_fetch_stage.sv
// IF stage: holds the fetch PC, selects the next PC from redirects, stall or the
// external adder, and loads the IF/ID register under a BOOT/RUN/HALT controller.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    output logic [31:0] adder_in1,
    output logic [31:0] adder_in2,
    input  logic [31:0] adder_sum,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic [31:0] fetch_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        BAD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            ifid_pc4_q    <= 32'h0;
            ifid_instr_q  <= 32'h0;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            BOOT: begin
                pc_d         = RESET_PC;
                ifid_pc4_d   = 32'h0;
                ifid_instr_d = 32'h0;
                ifid_valid_d = 1'b0;
                state_d      = RUN;
            end
            RUN: begin
                // Redirects win over stall and squash whatever was being fetched.
                if (branch_taken || jump) begin
                    pc_d         = branch_taken ? branch_target : jump_target;
                    ifid_pc4_d   = 32'h0;
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d          = adder_sum;
                    ifid_pc4_d    = adder_sum;
                    ifid_instr_d  = instr;
                    ifid_valid_d  = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
                // This cycle's update still lands; the freeze starts next cycle.
                if (halt_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign pc          = pc_q;
    assign adder_in1   = pc_q;
    assign adder_in2   = PC_STEP;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_valid  = ifid_valid_q;
    assign fetch_count = fetch_count_q;
    assign state       = state_q;

endmodule
